// File: rtl/store_write_buffer_if.sv
// Store write buffer bus: commit port from the store queue, memory write port,
// and the load-forwarding lookup. master = store queue/memory side, slave = buffer.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

interface store_write_buffer_if #(
  parameter int WB_SEL = 2
);
  logic                 commit_valid;
  logic [`ADDR_LEN-1:0] commit_address;
  logic [`DATA_LEN-1:0] commit_data;
  logic                 commit_ready;
  logic                 mem_req;
  logic [`ADDR_LEN-1:0] mem_addr;
  logic [`DATA_LEN-1:0] mem_wdata;
  logic                 mem_ack;
  logic [`ADDR_LEN-1:0] fwd_address;
  logic                 fwd_hit;
  logic [`DATA_LEN-1:0] fwd_data;
  logic                 wb_empty;
  logic [WB_SEL:0]      wb_count;

  modport master (
    output commit_valid, commit_address, commit_data, mem_ack, fwd_address,
    input  commit_ready, mem_req, mem_addr, mem_wdata, fwd_hit, fwd_data,
           wb_empty, wb_count
  );

  modport slave (
    input  commit_valid, commit_address, commit_data, mem_ack, fwd_address,
    output commit_ready, mem_req, mem_addr, mem_wdata, fwd_hit, fwd_data,
           wb_empty, wb_count
  );
endinterface

// File: rtl/store_write_buffer.sv
// Circular store write buffer: accepts committed stores, drains them to memory
// one at a time in commit order, and forwards the youngest matching store to loads.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module store_write_buffer #(
  parameter int WB_NUM = 4,
  parameter int WB_SEL = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  store_write_buffer_if.slave  bus
);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [`ADDR_LEN-1:0] r_addr [WB_NUM];
  logic [`DATA_LEN-1:0] r_data [WB_NUM];
  logic [WB_NUM-1:0]    r_vld;
  logic [WB_SEL-1:0]    r_head;
  logic [WB_SEL-1:0]    r_tail;
  logic [WB_SEL:0]      r_count;
  logic [`ADDR_LEN-1:0] r_mem_addr;
  logic [`DATA_LEN-1:0] r_mem_wdata;

  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_latch;
  logic                 w_mem_req;
  logic                 w_fwd_hit;
  logic [`DATA_LEN-1:0] w_fwd_data;
  logic [WB_SEL-1:0]    w_fwd_idx;

  // Ready looks only at the registered count, so a full buffer never accepts
  // a store even when the head is being retired on the same edge.
  assign w_ready = (r_count < (WB_SEL+1)'(WB_NUM));
  assign w_push  = bus.commit_valid && w_ready;
  assign w_pop   = (r_state == S_REQ) && bus.mem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_state_nxt = S_REQ;
      S_REQ:   if (bus.mem_ack)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_req = (r_state == S_REQ);
    w_latch   = (r_state == S_IDLE) && (r_count != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + WB_SEL'(1);
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + WB_SEL'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (WB_SEL+1)'(1);
        2'b01:   r_count <= r_count - (WB_SEL+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.commit_address;
      r_data[r_tail] <= bus.commit_data;
    end
  end

  // Head entry is captured on the IDLE->REQ edge and held until acknowledged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_latch) begin
      r_mem_addr  <= r_addr[r_head];
      r_mem_wdata <= r_data[r_head];
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_fwd_idx  = r_head;
    for (int i = 0; i < WB_NUM; i++) begin
      w_fwd_idx = r_head + WB_SEL'(i);
      if (r_vld[w_fwd_idx] && (r_addr[w_fwd_idx] == bus.fwd_address)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[w_fwd_idx];
      end
    end
  end

  assign bus.commit_ready = w_ready;
  assign bus.mem_req      = w_mem_req;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.fwd_hit      = w_fwd_hit;
  assign bus.fwd_data     = w_fwd_data;
  assign bus.wb_empty     = (r_count == '0);
  assign bus.wb_count     = r_count;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: single store, fill/full, wrap-around,
// forwarding, simultaneous push/pop and mid-request reset.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module tb_store_write_buffer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  store_write_buffer_if #(.WB_SEL(2)) bus ();

  store_write_buffer #(.WB_NUM(4), .WB_SEL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    bus.commit_valid   = 1'b1;
    bus.commit_address = a;
    bus.commit_data    = d;
    @(negedge clk);
    bus.commit_valid   = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int k;
    k = 0;
    while (bus.mem_req !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (bus.mem_req !== 1'b1) chk("req_timeout", 64'(bus.mem_req), 64'd1);
  endtask

  task automatic drain_one(input logic [31:0] ea, input logic [31:0] ed, input int dly);
    wait_req(40);
    chk("drain_addr", 64'(bus.mem_addr), 64'(ea));
    chk("drain_data", 64'(bus.mem_wdata), 64'(ed));
    repeat (dly) begin
      @(negedge clk);
      chk("hold_addr", 64'(bus.mem_addr), 64'(ea));
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
  endtask

  int dly_tab [10] = '{0, 3, 1, 2, 0, 3, 2, 1, 0, 3};

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.commit_valid   = 1'b0;
    bus.commit_address = '0;
    bus.commit_data    = '0;
    bus.mem_ack        = 1'b0;
    bus.fwd_address    = 32'h100;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_ready", 64'(bus.commit_ready), 64'd1);
    chk("rst_empty", 64'(bus.wb_empty), 64'd1);
    chk("rst_count", 64'(bus.wb_count), 64'd0);
    chk("rst_req",   64'(bus.mem_req), 64'd0);
    chk("rst_maddr", 64'(bus.mem_addr), 64'd0);
    chk("rst_hit",   64'(bus.fwd_hit), 64'd0);
    chk("rst_fdata", 64'(bus.fwd_data), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // single store latency
    push(32'h100, 32'hAA);
    chk("s1_req_e0", 64'(bus.mem_req), 64'd0);
    chk("s1_count",  64'(bus.wb_count), 64'd1);
    @(negedge clk);
    chk("s1_req_e1", 64'(bus.mem_req), 64'd1);
    chk("s1_addr",   64'(bus.mem_addr), 64'h100);
    chk("s1_data",   64'(bus.mem_wdata), 64'hAA);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("s1_empty",  64'(bus.wb_empty), 64'd1);
    chk("s1_req_dn", 64'(bus.mem_req), 64'd0);

    // fill and full
    for (int i = 0; i < 4; i++) push(32'h110 + 32'(4*i), 32'hB0 + 32'(i));
    chk("full_ready", 64'(bus.commit_ready), 64'd0);
    chk("full_count", 64'(bus.wb_count), 64'd4);
    chk("full_addr",  64'(bus.mem_addr), 64'h110);
    push(32'h1F0, 32'hFF);
    chk("full_ign",   64'(bus.wb_count), 64'd4);
    bus.fwd_address = 32'h1F0;
    #1 chk("full_nofwd", 64'(bus.fwd_hit), 64'd0);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("full_ack_ready", 64'(bus.commit_ready), 64'd1);
    chk("full_ack_count", 64'(bus.wb_count), 64'd3);
    for (int i = 1; i < 4; i++) drain_one(32'h110 + 32'(4*i), 32'hB0 + 32'(i), 0);
    chk("full_empty", 64'(bus.wb_empty), 64'd1);

    // wrap-around with concurrent push and variable ack delay
    fork
      begin
        int pi;
        int k;
        pi = 0;
        k  = 0;
        while (pi < 10 && k < 300) begin
          if (bus.commit_ready) begin
            bus.commit_valid   = 1'b1;
            bus.commit_address = 32'h300 + 32'(4*pi);
            bus.commit_data    = 32'h50 + 32'(pi);
            pi++;
          end else begin
            bus.commit_valid = 1'b0;
          end
          @(negedge clk);
          k++;
        end
        bus.commit_valid = 1'b0;
        if (pi < 10) chk("wrap_push_timeout", 64'(pi), 64'd10);
      end
      begin
        for (int i = 0; i < 10; i++) drain_one(32'h300 + 32'(4*i), 32'h50 + 32'(i), dly_tab[i]);
      end
    join
    chk("wrap_empty", 64'(bus.wb_empty), 64'd1);
    chk("wrap_count", 64'(bus.wb_count), 64'd0);

    // forwarding: youngest match wins, including the entry under request
    push(32'h200, 32'h11);
    push(32'h204, 32'h22);
    push(32'h200, 32'h33);
    bus.fwd_address = 32'h200;
    #1 chk("fwd_hit_200",  64'(bus.fwd_hit), 64'd1);
    chk("fwd_data_200", 64'(bus.fwd_data), 64'h33);
    bus.fwd_address = 32'h204;
    #1 chk("fwd_data_204", 64'(bus.fwd_data), 64'h22);
    bus.fwd_address = 32'h208;
    #1 chk("fwd_hit_208",  64'(bus.fwd_hit), 64'd0);
    chk("fwd_data_208", 64'(bus.fwd_data), 64'd0);
    bus.commit_valid   = 1'b1;
    bus.commit_address = 32'h208;
    bus.commit_data    = 32'h44;
    #1 chk("fwd_same_cyc", 64'(bus.fwd_hit), 64'd0);
    @(negedge clk);
    bus.commit_valid = 1'b0;
    chk("fwd_after_push", 64'(bus.fwd_data), 64'h44);
    drain_one(32'h200, 32'h11, 1);
    bus.fwd_address = 32'h200;
    #1 chk("fwd_after_pop", 64'(bus.fwd_data), 64'h33);
    drain_one(32'h204, 32'h22, 0);
    drain_one(32'h200, 32'h33, 0);
    drain_one(32'h208, 32'h44, 0);
    chk("fwd_empty", 64'(bus.wb_empty), 64'd1);

    // simultaneous push and pop
    push(32'h400, 32'h01);
    push(32'h404, 32'h02);
    chk("pp_req",   64'(bus.mem_req), 64'd1);
    chk("pp_count", 64'(bus.wb_count), 64'd2);
    bus.commit_valid   = 1'b1;
    bus.commit_address = 32'h408;
    bus.commit_data    = 32'h03;
    bus.mem_ack        = 1'b1;
    @(negedge clk);
    bus.commit_valid = 1'b0;
    bus.mem_ack      = 1'b0;
    chk("pp_count_keep", 64'(bus.wb_count), 64'd2);
    drain_one(32'h404, 32'h02, 0);
    drain_one(32'h408, 32'h03, 0);
    chk("pp_empty", 64'(bus.wb_empty), 64'd1);

    // reset while a request is outstanding
    push(32'h500, 32'h0D);
    push(32'h504, 32'h0E);
    push(32'h508, 32'h0F);
    chk("mr_req_pre", 64'(bus.mem_req), 64'd1);
    bus.fwd_address = 32'h504;
    #1 chk("mr_fwd_pre", 64'(bus.fwd_hit), 64'd1);
    #2 reset = 1'b0;
    bus.mem_ack = 1'b1;
    #1 chk("mr_req",   64'(bus.mem_req), 64'd0);
    chk("mr_count", 64'(bus.wb_count), 64'd0);
    chk("mr_empty", 64'(bus.wb_empty), 64'd1);
    chk("mr_ready", 64'(bus.commit_ready), 64'd1);
    chk("mr_fwd",   64'(bus.fwd_hit), 64'd0);
    chk("mr_maddr", 64'(bus.mem_addr), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mr_no_write", 64'(bus.mem_req), 64'd0);
      chk("mr_cnt_post", 64'(bus.wb_count), 64'd0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
